mesh_pkt_injector: RTL and testbench

- Per-node traffic source that drives the processor (P, direction 0) input port of one mesh router with coordinate-tagged packets over a valid/ready_and handshake.
- It is the transmit-side counterpart to the mesh data-integrity checker. It emits packets in the format the checker tracks, tagged with the source node, so end-to-end delivery can be attributed per source.
- One instance is placed per mesh node in the 2x2 (and larger) formal and simulation harnesses.

---
 rtl/mesh_pkt_pkg.sv | 53 +++++
 rtl/mesh_pkt_payload_gen.sv | 41 ++++
 rtl/mesh_pkt_injector.sv | 153 +++++++++++++++
 tb/tb_mesh_pkt_injector.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkt_pkg.sv
// Shared types for the mesh packet injector: FSM states, default packet layout,
// packet width helper and Galois LFSR tap masks (widths 3..16).
// No ports; imported by mesh_pkt_payload_gen and mesh_pkt_injector.
package mesh_pkt_pkg;

  localparam int MESH_X_W = 1;
  localparam int MESH_Y_W = 1;
  localparam int MESH_D_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Destination sits in the LSBs so {dest_y, dest_x} is directly the linear
  // node index with X as the low bits.
  typedef struct packed {
    logic [MESH_Y_W-1:0] src_y;
    logic [MESH_X_W-1:0] src_x;
    logic [MESH_D_W-1:0] payload;
    logic [MESH_Y_W-1:0] dest_y;
    logic [MESH_X_W-1:0] dest_x;
  } mesh_pkt_s;

  function automatic int pkt_width(input int x_w, input int y_w, input int d_w);
    return 2 * (x_w + y_w) + d_w;
  endfunction

  // Right-shifting Galois masks (XORed in when the shifted-out bit is 1),
  // all maximal length.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0E08;
      13:      return 16'h1C80;
      14:      return 16'h3802;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/mesh_pkt_payload_gen.sv
// Payload source: incrementing counter from 1, or a Galois LFSR seeded {1,0..0}
// when MESH_PKT_INJ_LFSR_PAYLOAD_EN is defined. Latency: payload_o is the
// current value, payload_nxt_o the value after one advance; advance_i steps it.
// Ports: clk, reset_n (async active-low), advance_i, payload_o, payload_nxt_o.
module mesh_pkt_payload_gen
  import mesh_pkt_pkg::*;
#(
  parameter int data_width_p = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    advance_i,
  output logic [data_width_p-1:0] payload_o,
  output logic [data_width_p-1:0] payload_nxt_o
);

  logic [data_width_p-1:0] pay_q;

`ifdef MESH_PKT_INJ_LFSR_PAYLOAD_EN
  localparam logic [data_width_p-1:0] TAPS = data_width_p'(lfsr_taps(data_width_p));
  localparam logic [data_width_p-1:0] SEED = data_width_p'(1) << (data_width_p - 1);

  // A maximal-length mask never lets a non-zero state fall to all-zeros.
  assign payload_nxt_o = pay_q[0] ? ((pay_q >> 1) ^ TAPS) : (pay_q >> 1);
`else
  localparam logic [data_width_p-1:0] SEED = data_width_p'(1);

  assign payload_nxt_o = pay_q + data_width_p'(1);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pay_q <= SEED;
    end else if (advance_i) begin
      pay_q <= payload_nxt_o;
    end
  end

  assign payload_o = pay_q;

endmodule

// File: rtl/mesh_pkt_injector.sv
// Per-node traffic source for a mesh router P port: bursts of coordinate-tagged
// packets. Latency: first packet valid the cycle after start_i; 1 pkt/cycle with
// gap 0. Backpressure: v_o/data_o hold stable until ready_and_i completes it.
// Ports: start_i/num_pkts_i/gap_i/sweep_i/dest_x_i/dest_y_i launch a burst;
// v_o/data_o/ready_and_i handshake; busy_o, done_o, sent_cnt_o status.
// Optional: MESH_PKT_INJ_LFSR_PAYLOAD_EN selects the LFSR payload source.
module mesh_pkt_injector
  import mesh_pkt_pkg::*;
#(
  parameter int x_cord_width_p = 1,
  parameter int y_cord_width_p = 1,
  parameter int data_width_p   = 4,
  parameter int my_x_p         = 0,
  parameter int my_y_p         = 0,
  parameter int cnt_width_p    = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start_i,
  input  logic [cnt_width_p-1:0]    num_pkts_i,
  input  logic [cnt_width_p-1:0]    gap_i,
  input  logic                      sweep_i,
  input  logic [x_cord_width_p-1:0] dest_x_i,
  input  logic [y_cord_width_p-1:0] dest_y_i,
  output logic                      v_o,
  output logic [pkt_width(x_cord_width_p, y_cord_width_p, data_width_p)-1:0] data_o,
  input  logic                      ready_and_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [cnt_width_p-1:0]    sent_cnt_o
);

  localparam int XY_W  = x_cord_width_p + y_cord_width_p;
  localparam int PKT_W = pkt_width(x_cord_width_p, y_cord_width_p, data_width_p);
  // {my_y, my_x} doubles as this node's linear index and the source field.
  localparam logic [XY_W-1:0] OWN_IDX = XY_W'((my_y_p << x_cord_width_p) + my_x_p);

  state_e state_q, state_d;

  logic [cnt_width_p-1:0]  rem_q, gap_q, gap_cnt_q, sent_q;
  logic                    sweep_q, zero_done_q;
  logic [PKT_W-1:0]        data_q, data_d;
  logic [XY_W-1:0]         rot_q;

  logic                    launch, xfer, last_pkt;
  logic [data_width_p-1:0] pay_cur, pay_nxt, pay_sel;
  logic [XY_W-1:0]         cur_dest, rot_adv, rot_base, sweep_dest, dest_sel;
  logic                    sweep_sel;

  assign xfer     = (state_q == SEND) && ready_and_i;
  assign launch   = (state_q == IDLE) && start_i && (num_pkts_i != '0);
  assign last_pkt = (rem_q == cnt_width_p'(1));
  assign cur_dest = data_q[XY_W-1:0];
  assign rot_adv  = cur_dest + XY_W'(1);

  mesh_pkt_payload_gen #(
    .data_width_p(data_width_p)
  ) u_payload_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .advance_i    (xfer),
    .payload_o    (pay_cur),
    .payload_nxt_o(pay_nxt)
  );

  // Next packet. At launch the generator/rotator hold the values for the first
  // packet; on a transfer the packet after the one just accepted is needed, so
  // the advanced payload and (current dest + 1) are used instead.
  always_comb begin
    rot_base   = launch ? rot_q : rot_adv;
    sweep_dest = (rot_base == OWN_IDX) ? rot_base + XY_W'(1) : rot_base;
    sweep_sel  = launch ? sweep_i : sweep_q;
    dest_sel   = cur_dest;
    if (sweep_sel) begin
      dest_sel = sweep_dest;
    end else if (launch) begin
      dest_sel = {dest_y_i, dest_x_i};
    end
    pay_sel = launch ? pay_cur : pay_nxt;
    data_d  = {OWN_IDX, pay_sel, dest_sel};
  end

  always_comb begin
    state_d = state_q;
    v_o     = 1'b0;
    busy_o  = 1'b1;
    done_o  = zero_done_q;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (launch) state_d = SEND;
      end
      SEND: begin
        v_o = 1'b1;
        if (xfer) begin
          if (last_pkt)           state_d = DONE;
          else if (gap_q != '0)   state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = SEND;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      sent_q      <= '0;
      sweep_q     <= 1'b0;
      zero_done_q <= 1'b0;
      data_q      <= '0;
      rot_q       <= '0;
    end else begin
      state_q     <= state_d;
      // A zero-length burst never leaves IDLE; it only reports completion.
      zero_done_q <= (state_q == IDLE) && start_i && (num_pkts_i == '0);

      if ((state_q == IDLE) && start_i) begin
        sent_q  <= '0;
        rem_q   <= num_pkts_i;
        gap_q   <= gap_i;
        sweep_q <= sweep_i;
      end else if (xfer) begin
        rem_q <= rem_q - cnt_width_p'(1);
        if (sent_q != '1) sent_q <= sent_q + cnt_width_p'(1);
      end

      if (xfer && (state_d == GAP)) begin
        gap_cnt_q <= gap_q - cnt_width_p'(1);
      end else if ((state_q == GAP) && (gap_cnt_q != '0)) begin
        gap_cnt_q <= gap_cnt_q - cnt_width_p'(1);
      end

      if (launch || xfer) data_q <= data_d;

      // Rotator moves only on sweep-mode transfers and survives across bursts.
      if (xfer && sweep_q) rot_q <= rot_adv;
    end
  end

  assign data_o     = data_q;
  assign sent_cnt_o = sent_q;

endmodule

// File: tb/tb_mesh_pkt_injector.sv
// Bench for mesh_pkt_injector: nodes (0,0) and (1,0) share stimulus; a
// packet-list reference model predicts every packet, valid cycle and done.
module tb_mesh_pkt_injector;
  import mesh_pkt_pkg::*;

  localparam int PW = pkt_width(1, 1, 4);
`ifdef MESH_PKT_INJ_LFSR_PAYLOAD_EN
  localparam logic [PW-1:0] MASK = 10'b11_0000_11;
`else
  localparam logic [PW-1:0] MASK = '1;
`endif

  logic clk = 1'b0, reset_n = 1'b1, start_i = 1'b0;
  logic [7:0] num_pkts_i = '0, gap_i = '0;
  logic sweep_i = 1'b0, dest_x_i = 1'b0, dest_y_i = 1'b0, ready_and_i = 1'b0;
  logic v0, v1, busy0, busy1, done0, done1;
  logic [PW-1:0] d0, d1;
  logic [7:0] sent0, sent1;

  int n_tests = 0, n_fail = 0;
  int m_pay;
  int m_rot[2];
  logic [PW-1:0] exp_q0[$], exp_q1[$];
  logic [3:0] obs_pay[$];

  always #5 clk = ~clk;

  mesh_pkt_injector #(.my_x_p(0), .my_y_p(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .num_pkts_i(num_pkts_i),
    .gap_i(gap_i), .sweep_i(sweep_i), .dest_x_i(dest_x_i), .dest_y_i(dest_y_i),
    .v_o(v0), .data_o(d0), .ready_and_i(ready_and_i), .busy_o(busy0),
    .done_o(done0), .sent_cnt_o(sent0));

  mesh_pkt_injector #(.my_x_p(1), .my_y_p(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .num_pkts_i(num_pkts_i),
    .gap_i(gap_i), .sweep_i(sweep_i), .dest_x_i(dest_x_i), .dest_y_i(dest_y_i),
    .v_o(v1), .data_o(d1), .ready_and_i(ready_and_i), .busy_o(busy1),
    .done_o(done1), .sent_cnt_o(sent1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected packets for both nodes: payload counts up from 1 mod 16; sweep
  // destinations walk node indices upward, skipping the node's own index.
  task automatic model_fill(input int num, input bit sweep, input int dx, input int dy);
    for (int k = 0; k < num; k++) begin
      int pay;
      pay   = m_pay;
      m_pay = (m_pay + 1) % 16;
      for (int n = 0; n < 2; n++) begin
        int d;
        mesh_pkt_s p;
        if (sweep) begin
          d = m_rot[n];
          if (d == n) d = (d + 1) % 4;
          m_rot[n] = (d + 1) % 4;
        end else begin
          d = dy * 2 + dx;
        end
        p.src_y   = 1'(n / 2);
        p.src_x   = 1'(n % 2);
        p.payload = 4'(pay);
        p.dest_y  = 1'(d / 2);
        p.dest_x  = 1'(d % 2);
        if (n == 0) exp_q0.push_back(p);
        else        exp_q1.push_back(p);
      end
    end
  endtask

  task automatic model_reset();
    m_pay    = 1;
    m_rot[0] = 0;
    m_rot[1] = 0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic run_burst(input int num, input int gap, input bit sweep, input int dx,
                           input int dy, input int rdy_pct, input bit poke,
                           output logic [PW-1:0] first0, output logic [PW-1:0] first1);
    bit exp_v, expect_done, finished, got_first, rdy, prev_hold;
    int wait_cyc;
    logic [PW-1:0] prev_d0;
    model_fill(num, sweep, dx, dy);
    @(negedge clk);
    start_i = 1'b1; num_pkts_i = 8'(num); gap_i = 8'(gap); sweep_i = sweep;
    dest_x_i = 1'(dx); dest_y_i = 1'(dy); ready_and_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    expect_done = (num == 0); finished = 0; got_first = 0; prev_hold = 0;
    wait_cyc = 0; first0 = '0; first1 = '0; prev_d0 = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_v = (exp_q0.size() > 0) && (wait_cyc == 0);
      check("valid0", v0, exp_v);
      check("valid1", v1, exp_v);
      check("done0", done0, expect_done);
      check("done1", done1, expect_done);
      check("busy0", busy0, num != 0);
      if (prev_hold) check("hold_data", d0, prev_d0);
      if (expect_done) begin
        check("sent0", sent0, num);
        check("sent1", sent1, num);
        finished = 1;
        break;
      end
      if (exp_v) begin
        check("pkt0", d0 & MASK, exp_q0[0] & MASK);
        check("pkt1", d1 & MASK, exp_q1[0] & MASK);
      end else if (wait_cyc > 0) begin
        wait_cyc--;
      end
      start_i = poke && (cyc == 2);
      if (start_i) begin
        num_pkts_i = 8'd7; sweep_i = ~sweep;
      end
      rdy = ($urandom_range(0, 99) < rdy_pct);
      ready_and_i = rdy;
      if (exp_v && rdy) begin
        if (!got_first) begin first0 = d0; first1 = d1; got_first = 1; end
        obs_pay.push_back(d0[5:2]);
        void'(exp_q0.pop_front());
        void'(exp_q1.pop_front());
        wait_cyc = gap;
        if (exp_q0.size() == 0) expect_done = 1;
      end
      prev_hold = exp_v && !rdy;
      prev_d0   = d0;
      @(negedge clk);
    end
    start_i = 1'b0;
    ready_and_i = 1'b0;
    if (!finished) check("burst_timeout", 0, 1);
  endtask

  typedef struct {
    int num; int gap; bit sweep; int dx; int dy; int rdy; bit poke;
    int exp_sent; int exp_pay; int exp_dest1;
  } vec_t;

  initial begin
    vec_t vecs[7];
    logic [PW-1:0] f0, f1, snap;
    mesh_pkt_s p0, p1;

    vecs[0] = '{3, 0, 1'b0, 1, 0, 100, 1'b0, 3, 1, 1};
    vecs[1] = '{4, 0, 1'b1, 0, 0, 100, 1'b0, 4, 4, 0};
    vecs[2] = '{1, 0, 1'b1, 0, 0, 100, 1'b0, 1, 8, 2};
    vecs[3] = '{2, 3, 1'b0, 0, 1, 100, 1'b0, 2, 9, 2};
    vecs[4] = '{0, 0, 1'b0, 0, 0, 100, 1'b0, 0, -1, -1};
    vecs[5] = '{5, 1, 1'b1, 0, 0, 50, 1'b0, 5, 11, 3};
    vecs[6] = '{4, 2, 1'b0, 1, 1, 60, 1'b1, 4, 0, 3};

    model_reset();
    #3 reset_n = 1'b0;
    #1;
    check("rst_v", v0, 0);
    check("rst_data", d0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_sent", sent0, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_burst(vecs[i].num, vecs[i].gap, vecs[i].sweep, vecs[i].dx, vecs[i].dy,
                vecs[i].rdy, vecs[i].poke, f0, f1);
      p0 = f0; p1 = f1;
      check("vec_sent", sent0, vecs[i].exp_sent);
`ifndef MESH_PKT_INJ_LFSR_PAYLOAD_EN
      if (vecs[i].exp_pay >= 0) check("vec_pay", p0.payload, vecs[i].exp_pay);
`endif
      if (vecs[i].exp_dest1 >= 0) begin
        check("vec_dest1", {p1.dest_y, p1.dest_x}, vecs[i].exp_dest1);
        check("vec_src1", {p1.src_y, p1.src_x}, 1);
        check("vec_src0", {p0.src_y, p0.src_x}, 0);
      end
    end

    // Backpressure: five stalled cycles, then one transfer.
    @(negedge clk);
    start_i = 1'b1; num_pkts_i = 8'd1; gap_i = 8'd0; sweep_i = 1'b0;
    dest_x_i = 1'b1; dest_y_i = 1'b1; ready_and_i = 1'b0;
    model_fill(1, 1'b0, 1, 1);
    @(negedge clk);
    start_i = 1'b0;
    snap = d0;
    for (int i = 0; i < 5; i++) begin
      check("bp_v", v0, 1);
      check("bp_hold", d0, snap);
      check("bp_data", d0 & MASK, exp_q0[0] & MASK);
      check("bp_cnt", sent0, 0);
      @(negedge clk);
    end
    ready_and_i = 1'b1;
    @(negedge clk);
    ready_and_i = 1'b0;
    void'(exp_q0.pop_front());
    void'(exp_q1.pop_front());
    check("bp_sent", sent0, 1);
    check("bp_done", done0, 1);
    @(negedge clk);
    check("bp_sent_hold", sent0, 1);
    check("bp_idle", busy0, 0);
    check("bp_done_pulse", done0, 0);

    // Reset in the middle of a stalled burst.
    @(negedge clk);
    start_i = 1'b1; num_pkts_i = 8'd5; gap_i = 8'd0; sweep_i = 1'b0; ready_and_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    check("mid_v", v0, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_v", v0, 0);
    check("mid_rst_v1", v1, 0);
    check("mid_rst_data", d0, 0);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_done", done0, 0);
    check("mid_rst_sent", sent0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    run_burst(2, 0, 1'b1, 0, 0, 100, 1'b0, f0, f1);
    p0 = f0; p1 = f1;
`ifndef MESH_PKT_INJ_LFSR_PAYLOAD_EN
    check("post_rst_pay", p0.payload, 1);
`endif
    check("post_rst_dest0", {p0.dest_y, p0.dest_x}, 1);
    check("post_rst_dest1", {p1.dest_y, p1.dest_x}, 0);

    // Randomized bursts against the model.
    for (int r = 0; r < 25; r++) begin
      run_burst($urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(30, 100),
                1'($urandom_range(0, 1)), f0, f1);
    end

`ifdef MESH_PKT_INJ_LFSR_PAYLOAD_EN
    obs_pay.delete();
    run_burst(16, 0, 1'b0, 0, 0, 100, 1'b0, f0, f1);
    check("lfsr_count", obs_pay.size(), 16);
    if (obs_pay.size() == 16) begin
      for (int i = 0; i < 15; i++) begin
        check("lfsr_nonzero", {31'b0, obs_pay[i] != 4'd0}, 1);
        for (int j = 0; j < i; j++)
          check("lfsr_distinct", {31'b0, obs_pay[i] != obs_pay[j]}, 1);
      end
      check("lfsr_repeat", obs_pay[15], obs_pay[0]);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
